// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply/divide unit feeding the HI/LO register pair.
//
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract),
// one result bit per cycle, then writes HI/LO with a single-cycle pulse.
//
// Optional build macro:
//   MDU_FAST_MUL_EN  MULT/MULTU form the full product combinationally in PREP
//                    and skip RUN; results are bit-identical to the
//                    iterative build.
//
// Ports:
//   HI_LO_clk  in   clock, all state on posedge
//   HI_LO_rst  in   asynchronous active-high reset
//   start      in   op request, sampled only in IDLE
//   op         in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs, rt     in   multiplicand/dividend, multiplier/divisor
//   flush      in   synchronous abort of the op in flight (no write)
//   busy       out  high while an op is in flight (PREP..DONE)
//   done       out  one-cycle completion pulse
//   div_zero   out  with done, divide had rt == 0
//   hi_out     out  product high word / remainder
//   lo_out     out  product low word / quotient
//   hi_w,lo_w  out  HI/LO write enables, coincident with done
module mdu_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             HI_LO_clk,
   input  logic             HI_LO_rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             hi_w,
   output logic             lo_w
);

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      RUN,
      FIX,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [1:0]       op_r;
   logic [WIDTH-1:0] rs_r, rt_r;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH-1:0] opnd;
   logic [CNT_W-1:0] cnt;
   logic             q_neg, r_neg, dz, fix_ph;

   logic             is_div, is_sgn, rt_zero;
   logic [WIDTH-1:0] abs_rs, abs_rt;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift, div_diff;

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, abs_rs} * {{WIDTH{1'b0}}, abs_rt};
`endif

   // Operand conditioning: magnitudes for signed ops. The most negative value
   // maps onto itself, which is its correct unsigned magnitude.
   always_comb begin
      is_div  = op_r[1];
      is_sgn  = ~op_r[0];
      rt_zero = (rt_r == '0);
      abs_rs  = (is_sgn && rs_r[WIDTH-1]) ? (~rs_r + 1'b1) : rs_r;
      abs_rt  = (is_sgn && rt_r[WIDTH-1]) ? (~rt_r + 1'b1) : rt_r;
   end

   // One iteration of each algorithm.
   // Mult: acc_lo holds the remaining multiplier bits, product shifts in from the top.
   // Div:  acc_lo holds dividend bits shifting out and quotient bits shifting in.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
   end

   always_ff @(posedge HI_LO_clk or posedge HI_LO_rst) begin
      if (HI_LO_rst) state <= IDLE;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      done     = 1'b0;
      unique case (state)
         IDLE: if (start) state_nx = PREP;
         PREP: begin
            if (flush)                   state_nx = IDLE;
            else if (is_div && rt_zero)  state_nx = FIX;
`ifdef MDU_FAST_MUL_EN
            else if (!is_div)            state_nx = FIX;
`endif
            else                         state_nx = RUN;
         end
         RUN: begin
            if (flush)                           state_nx = IDLE;
            else if (cnt == CNT_W'(WIDTH - 1))   state_nx = FIX;
         end
         FIX: begin
            if (flush)       state_nx = IDLE;
            else if (fix_ph) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      hi_w     = done;
      lo_w     = done;
      div_zero = done & dz;
   end

   always_ff @(posedge HI_LO_clk or posedge HI_LO_rst) begin
      if (HI_LO_rst) begin
         op_r   <= '0;
         rs_r   <= '0;
         rt_r   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         cnt    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         dz     <= 1'b0;
         fix_ph <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  rs_r <= rs;
                  rt_r <= rt;
               end
            end
            PREP: begin
               cnt    <= '0;
               fix_ph <= 1'b0;
               dz     <= 1'b0;
               q_neg  <= is_sgn & (rs_r[WIDTH-1] ^ rt_r[WIDTH-1]);
               r_neg  <= is_sgn & is_div & rs_r[WIDTH-1];
               if (is_div) begin
                  if (rt_zero) begin
                     // Raw dividend to HI, all-ones to LO, no sign correction.
                     acc_hi <= rs_r;
                     acc_lo <= '1;
                     dz     <= 1'b1;
                     q_neg  <= 1'b0;
                     r_neg  <= 1'b0;
                  end else begin
                     acc_hi <= '0;
                     acc_lo <= abs_rs;
                     opnd   <= abs_rt;
                  end
               end else begin
`ifdef MDU_FAST_MUL_EN
                  {acc_hi, acc_lo} <= fast_prod;
`else
                  acc_hi <= '0;
                  acc_lo <= abs_rt;
                  opnd   <= abs_rs;
`endif
               end
            end
            RUN: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  if (!div_diff[WIDTH]) begin
                     acc_hi <= div_diff[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               // Two phases: sign correction in place, then the corrected
               // words are registered onto hi_out/lo_out entering DONE.
               if (!fix_ph) begin
                  fix_ph <= 1'b1;
                  if (is_div) begin
                     if (q_neg) acc_lo <= ~acc_lo + 1'b1;
                     if (r_neg) acc_hi <= ~acc_hi + 1'b1;
                  end else if (q_neg) begin
                     {acc_hi, acc_lo} <= ~{acc_hi, acc_lo} + 1'b1;
                  end
               end else if (!flush) begin
                  hi_out <= acc_hi;
                  lo_out <= acc_lo;
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

   localparam int unsigned W = 32;

   logic          HI_LO_clk = 1'b0;
   logic          HI_LO_rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  rs = '0;
   logic [W-1:0]  rt = '0;
   logic          flush = 1'b0;
   logic          busy, done, div_zero, hi_w, lo_w;
   logic [W-1:0]  hi_out, lo_out;

   int unsigned   errs = 0;
   int unsigned   checks = 0;
   logic [W-1:0]  prev_hi = '0;
   logic [W-1:0]  prev_lo = '0;

   mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
      .HI_LO_clk (HI_LO_clk),
      .HI_LO_rst (HI_LO_rst),
      .start     (start),
      .op        (op),
      .rs        (rs),
      .rt        (rt),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .hi_w      (hi_w),
      .lo_w      (lo_w)
   );

   always #5 HI_LO_clk = ~HI_LO_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: architectural semantics with plain integer arithmetic.
   task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      dz = 1'b0;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         2'b00: begin p = sa * sb; {hi, lo} = p; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
         default: begin
            if (b == 0) begin
               dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
            end else if (o == 2'b11) begin
               lo = a / b; hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 32'h0;
            end else begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end
         end
      endcase
   endtask

   function automatic int unsigned exp_lat(input logic [1:0] o, input logic [W-1:0] b);
      if (o[1] && b == 0) return 3;
`ifdef MDU_FAST_MUL_EN
      if (!o[1]) return 3;
`endif
      return W + 3;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold);
      logic [W-1:0] ehi, elo;
      logic         edz;
      int unsigned  n;
      bit           got, stable;
      model(o, a, b, ehi, elo, edz);
      @(negedge HI_LO_clk);
      start = 1'b1; op = o; rs = a; rt = b;
      @(posedge HI_LO_clk); #1;
      if (!hold) start = 1'b0;
      check("busy_after_start", busy, 1);
      n = 0; got = 0; stable = 1;
      while (n < 60 && !got) begin
         @(posedge HI_LO_clk); #1;
         n++;
         if (done) got = 1;
         else if (hi_out !== prev_hi || lo_out !== prev_lo || hi_w || lo_w) stable = 0;
      end
      check("done_seen", got, 1);
      check("outputs_stable_while_busy", stable, 1);
      check("latency", n, exp_lat(o, b));
      check("hi", hi_out, ehi);
      check("lo", lo_out, elo);
      check("div_zero", div_zero, edz);
      check("write_pulse", {hi_w, lo_w}, 2'b11);
      @(posedge HI_LO_clk); #1;
      check("idle_after_done", {busy, done, hi_w, lo_w}, 4'b0000);
      start = 1'b0;
      prev_hi = ehi; prev_lo = elo;
   endtask

   task automatic flush_test(input int unsigned at);
      int unsigned pulses;
      @(negedge HI_LO_clk);
      start = 1'b1; op = 2'b01; rs = 32'h0000_1234; rt = 32'h0000_5678;
      @(posedge HI_LO_clk); #1;
      start = 1'b0;
      repeat (at) @(posedge HI_LO_clk);
      #1 flush = 1'b1;
      @(posedge HI_LO_clk); #1;
      flush = 1'b0;
      check("flush_busy_drop", busy, 0);
      pulses = 0;
      repeat (40) begin
         @(posedge HI_LO_clk); #1;
         if (done || hi_w || lo_w) pulses++;
      end
      check("flush_no_write", pulses, 0);
      check("flush_hi_kept", hi_out, prev_hi);
      check("flush_lo_kept", lo_out, prev_lo);
   endtask

   initial begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      int unsigned  sel;
      repeat (2) @(negedge HI_LO_clk);
      #1;
      check("rst_outputs", {busy, done, div_zero, hi_w, lo_w}, 5'b0);
      check("rst_hi_lo", {hi_out, lo_out}, 64'h0);
      @(negedge HI_LO_clk);
      HI_LO_rst = 1'b0;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'b11, 32'd7, 32'd2, 0);
      run_op(2'b11, 32'h0000_1234, 32'h0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'b10, 32'h8000_0000, 32'h0, 0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'h1, 0);
      run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 1);   // start held high throughout
      flush_test(10);

      // Asynchronous reset in the middle of RUN.
      @(negedge HI_LO_clk);
      start = 1'b1; op = 2'b00; rs = 32'd99; rt = 32'd77;
      @(posedge HI_LO_clk); #1;
      start = 1'b0;
      repeat (15) @(posedge HI_LO_clk);
      #3 HI_LO_rst = 1'b1;
      #1;
      check("midrun_rst_ctrl", {busy, done, div_zero, hi_w, lo_w}, 5'b0);
      check("midrun_rst_hi_lo", {hi_out, lo_out}, 64'h0);
      @(negedge HI_LO_clk);
      HI_LO_rst = 1'b0;
      prev_hi = '0; prev_lo = '0;
      run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0);

      for (int unsigned i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         sel = $urandom_range(0, 15);
         if (sel == 0) b = '0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel < 5) b = 32'($urandom_range(1, 300));
         else if (sel < 7) b = -32'($urandom_range(1, 300));
         run_op(o, a, b, 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
